poly_op_sequencer: RTL and testbench
====================================

POLY_OP_SEQUENCER -- requirements
Module: poly_op_sequencer

Interface
- REQ-001: Parameter POLYDEG, default 8192: maximum coefficients per polynomial operation.
- REQ-002: Parameter NPLINE, default 16: fixed datapath latency in unstalled cycles from read issue to result write.
- REQ-003: Localparam AW = clog2(POLYDEG), which is 13 at default.
- REQ-004: clk, input, 1 bit: single clock; all logic is rising-edge.
- REQ-005: rst, input, 1 bit: synchronous, active-high reset.
- REQ-006: cmd_valid, input, 1 bit: a command is presented.
- REQ-007: cmd_ready, output, 1 bit: the sequencer accepts a command this cycle.
- REQ-008: cmd_op, input, 2 bits: 00 pointwise modmul, 01 modadd, 10 modsub, 11 copy.
- REQ-009: cmd_len, input, AW+1 bits: coefficient count; the legal range is 1..POLYDEG.
- REQ-010: cmd_abort, input, 1 bit: terminates the active operation.
- REQ-011: dp_stall, input, 1 bit: freezes issue and the in-flight tracker.
- REQ-012: rd_en, output, 1 bit: read strobe to the source banks.
- REQ-013: rd_addr, output, AW bits: source coefficient index.
- REQ-014: dp_op, output, 2 bits: latched opcode, driven to the datapath.
- REQ-015: wr_en, output, 1 bit: write strobe to the destination bank.
- REQ-016: wr_addr, output, AW bits: destination coefficient index.
- REQ-017: busy, output, 1 bit: high in any state other than IDLE.
- REQ-018: done, output, 1 bit: one-cycle completion pulse.
- REQ-019: err, output, 1 bit: valid while done is high; set for an illegal length or an abort.

Function
- REQ-020: The FSM SHALL have four states: IDLE, ISSUE, DRAIN, DONE.
- REQ-021: cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted when cmd_valid and cmd_ready are both high.
- REQ-022: On accept, the block SHALL latch cmd_op into dp_op and latch cmd_len, then go to DONE with err=1 if cmd_len==0 or cmd_len>POLYDEG, and to ISSUE otherwise.
- REQ-023: In ISSUE with dp_stall=0, the block SHALL assert rd_en and increment rd_addr from 0 by 1 each cycle.
- REQ-024: After issuing index len-1, the block SHALL go to DRAIN; rd_addr SHALL hold its last value and rd_en SHALL be 0.
- REQ-025: An NPLINE-deep valid shift register SHALL track reads; it SHALL shift only when dp_stall=0, and wr_en SHALL equal its output bit ANDed with !dp_stall.
- REQ-026: wr_addr SHALL start at 0 per command and increment after each wr_en.
- REQ-027: The write count SHALL equal the read count exactly.
- REQ-028: Without stalls, the first wr_en SHALL occur exactly NPLINE cycles after the first rd_en.
- REQ-029: The block SHALL go from DRAIN to DONE in the cycle after the write of index len-1.
- REQ-030: Timing, with accept at cycle T and no stall: first rd_en at T+1, last rd_en at T+len, last wr_en at T+len+NPLINE, done at T+len+NPLINE+1.
- REQ-031: In DONE, done SHALL be 1 for one cycle with err valid, then the FSM SHALL return to IDLE; no command SHALL be accepted in DONE.
- REQ-032: dp_stall=1 SHALL hold every counter, the shift register and the state, and SHALL force rd_en=wr_en=0; it SHALL have no effect in IDLE or DONE.
- REQ-033: cmd_abort in ISSUE or DRAIN SHALL take priority over dp_stall, clear the shift register, force rd_en=wr_en=0 from the next cycle, and go to DONE with err=1.
- REQ-034: cmd_abort in IDLE or DONE SHALL be ignored.
- REQ-035: cmd_len==POLYDEG SHALL complete with rd_addr and wr_addr ending at POLYDEG-1, with no wrap and no extra strobe.
- REQ-036: For cmd_len==1, the read SHALL occur at T+1 and the write at T+1+NPLINE.
- REQ-037: err SHALL be 0 on a normal completion.

Reset
- REQ-038: rst SHALL put the FSM in IDLE, including mid-operation, and in-flight writes SHALL be discarded.
- REQ-039: Reset values SHALL be: cmd_ready=1; rd_en=0, wr_en=0, done=0, err=0, busy=0; rd_addr=0, wr_addr=0, dp_op=0; shift register cleared.
- REQ-040: The first cycle after rst deasserts SHALL be able to accept a command.

Verification
- REQ-041: op=00, len=4, NPLINE=16, no stall -> rd_en at T+1..T+4 with addr 0..3; wr_en at T+17..T+20 with addr 0..3; done=1, err=0 at T+21; cmd_ready=1 at T+22.
- REQ-042: len=8 with dp_stall high for 3 cycles during ISSUE after the 2nd read -> rd/wr strobes are suppressed while stalled; 8 writes, addr 0..7 in order; done 3 cycles later than the unstalled T+25.
- REQ-043: len=0, and separately len=POLYDEG+1 -> no rd_en and no wr_en; done=1, err=1 at T+1.
- REQ-044: len=100 with cmd_abort at the 50th read -> no strobes from the next cycle; done=1, err=1 one cycle after abort; the next command runs normally from addr 0.
- REQ-045: len=POLYDEG -> exactly 8192 reads and 8192 writes; final addresses 8191; no wrap.
- REQ-046: rst asserted in DRAIN with 10 writes in flight -> no further wr_en; all outputs at reset values; a new command is accepted on the first post-reset cycle.

Source files
------------

// File: rtl/poly_op_sequencer.sv
// poly_op_sequencer: issues coefficient reads for one polynomial operation,
// tracks them through a fixed-latency datapath and issues the matching writes.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_op, cmd_len      : opcode and coefficient count (legal 1..POLYDEG)
//   cmd_abort            : terminates an active operation with err
//   dp_stall             : freezes issue, tracker and counters
//   rd_en, rd_addr       : source bank read strobe and index
//   dp_op                : latched opcode for the datapath
//   wr_en, wr_addr       : destination bank write strobe and index
//   busy, done, err      : status; err valid while done is high
module poly_op_sequencer #(
   parameter int unsigned POLYDEG = 8192,
   parameter int unsigned NPLINE  = 16,
   localparam int unsigned AW     = $clog2(POLYDEG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW:0]   cmd_len,
   input  logic          cmd_abort,
   input  logic          dp_stall,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic [1:0]    dp_op,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [LW-1:0]     len_q, len_d;
   logic [1:0]        op_q, op_d;
   logic              err_q, err_d;
   logic [NPLINE-1:0] sr_q, sr_d;

   logic              active_c;
   logic [AW-1:0]     last_idx_c;

   // State and datapath-control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         len_q     <= '0;
         op_q      <= '0;
         err_q     <= 1'b0;
         sr_q      <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         len_q     <= len_d;
         op_q      <= op_d;
         err_q     <= err_d;
         sr_q      <= sr_d;
      end
   end

   // Next-state, counters, in-flight tracker and strobes
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      len_d     = len_q;
      op_d      = op_q;
      err_d     = err_q;
      sr_d      = sr_q;

      active_c   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      last_idx_c = AW'(len_q - LW'(1));
      // Strobes in the abort cycle still go out; they stop from the next cycle
      rd_en      = (state_q == S_ISSUE) && !dp_stall;
      wr_en      = active_c && sr_q[NPLINE-1] && !dp_stall;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d      = cmd_op;
               len_d     = cmd_len;
               rd_addr_d = '0;
               wr_addr_d = '0;
               sr_d      = '0;
               if ((cmd_len == '0) || (cmd_len > LW'(POLYDEG))) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (cmd_abort) begin
               sr_d    = '0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (!dp_stall) begin
               sr_d = (sr_q << 1) | NPLINE'(1);
               if (rd_addr_q == last_idx_c) begin
                  state_d = S_DRAIN;
               end else begin
                  rd_addr_d = AW'(rd_addr_q + AW'(1));
               end
               // Writes overlap issue when len exceeds the pipeline depth
               if (wr_en && (wr_addr_q != last_idx_c)) begin
                  wr_addr_d = AW'(wr_addr_q + AW'(1));
               end
            end
         end
         S_DRAIN: begin
            if (cmd_abort) begin
               sr_d    = '0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (!dp_stall) begin
               sr_d = sr_q << 1;
               if (wr_en) begin
                  // Hold on the final index so POLYDEG-1 never wraps
                  if (wr_addr_q == last_idx_c) begin
                     state_d = S_DONE;
                  end else begin
                     wr_addr_d = AW'(wr_addr_q + AW'(1));
                  end
               end
            end
         end
         S_DONE: begin
            sr_d    = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = done && err_q;
   assign rd_addr   = rd_addr_q;
   assign wr_addr   = wr_addr_q;
   assign dp_op     = op_q;

endmodule

// File: tb/tb_poly_op_sequencer.sv
// Scoreboard bench for poly_op_sequencer: directed commands push expected
// read/write/done events (cycle, index, opcode or err); a negedge monitor pops
// and compares each strobe the DUT presents.
module tb_poly_op_sequencer;

   localparam int unsigned POLYDEG = 8192;
   localparam int unsigned NPLINE  = 16;
   localparam int unsigned AW      = $clog2(POLYDEG);

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW:0]   cmd_len;
   logic          cmd_abort;
   logic          dp_stall;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [1:0]    dp_op;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          busy;
   logic          done;
   logic          err;

   poly_op_sequencer #(.POLYDEG(POLYDEG), .NPLINE(NPLINE)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .cmd_abort (cmd_abort),
      .dp_stall  (dp_stall),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .dp_op     (dp_op),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int val;
      int op;
   } ev_t;

   ev_t exp_rd[$];
   ev_t exp_wr[$];
   ev_t exp_done[$];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
      end
   endtask

   function automatic ev_t mk(input int c, input int v, input int o);
      ev_t e;
      e.cyc = c;
      e.val = v;
      e.op  = o;
      return e;
   endfunction

   // Monitor: every strobe must match the head of its expectation queue
   always @(negedge clk) begin
      ev_t e;
      if (rd_en) begin
         if (exp_rd.size() == 0) chk("rd_unexpected", int'(rd_addr), -1);
         else begin
            e = exp_rd.pop_front();
            chk("rd_cycle", cyc, e.cyc);
            chk("rd_addr", int'(rd_addr), e.val);
            chk("rd_op", int'(dp_op), e.op);
         end
      end
      if (wr_en) begin
         if (exp_wr.size() == 0) chk("wr_unexpected", int'(wr_addr), -1);
         else begin
            e = exp_wr.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_addr", int'(wr_addr), e.val);
         end
      end
      if (done) begin
         if (exp_done.size() == 0) chk("done_unexpected", int'(err), -1);
         else begin
            e = exp_done.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_err", int'(err), e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   // Present a command in the current cycle; t returns the accept cycle
   task automatic issue(input logic [1:0] op, input int len, output int t);
      int n = 0;
      while (!cmd_ready && n < 200) begin
         step();
         n++;
      end
      if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
      t         = cyc;
      cmd_op    = op;
      cmd_len   = (AW+1)'(len);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   // Unstalled, unaborted command accepted at cycle t
   task automatic push_normal(input int t, input int len, input int op);
      for (int i = 0; i < len; i++) begin
         exp_rd.push_back(mk(t + 1 + i, i, op));
         exp_wr.push_back(mk(t + 1 + NPLINE + i, i, op));
      end
      exp_done.push_back(mk(t + len + NPLINE + 1, 0, op));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      chk({tag, "_rd_en"},     int'(rd_en), 0);
      chk({tag, "_wr_en"},     int'(wr_en), 0);
      chk({tag, "_done"},      int'(done), 0);
      chk({tag, "_err"},       int'(err), 0);
      chk({tag, "_busy"},      int'(busy), 0);
      chk({tag, "_rd_addr"},   int'(rd_addr), 0);
      chk({tag, "_wr_addr"},   int'(wr_addr), 0);
      chk({tag, "_dp_op"},     int'(dp_op), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      int t2;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_len   = '0;
      cmd_abort = 1'b0;
      dp_stall  = 1'b0;
      step();
      step();
      step();
      chk_reset_outputs("reset");
      rst = 1'b0;

      // Basic modmul, len 4, accepted on the first post-reset cycle
      issue(2'b00, 4, t);
      push_normal(t, 4, 0);
      wait_until(t + 22);
      chk("len4_ready_T22", int'(cmd_ready), 1);
      chk("len4_busy_T22", int'(busy), 0);

      // Single coefficient modadd
      issue(2'b01, 1, t);
      push_normal(t, 1, 1);
      wait_until(t + NPLINE + 3);

      // Reads and writes overlapping (len > NPLINE), modsub
      issue(2'b10, 20, t);
      push_normal(t, 20, 2);
      wait_until(t + 20 + NPLINE + 2);

      // Stall for 3 cycles after the 2nd read: everything slips by 3
      issue(2'b11, 8, t);
      for (int i = 0; i < 8; i++) begin
         exp_rd.push_back(mk((i < 2) ? (t + 1 + i) : (t + 4 + i), i, 3));
         exp_wr.push_back(mk(t + 20 + i, i, 3));
      end
      exp_done.push_back(mk(t + 28, 0, 3));
      wait_until(t + 3);
      dp_stall = 1'b1;
      wait_until(t + 6);
      dp_stall = 1'b0;
      wait_until(t + 29);

      // Illegal lengths: immediate done with err
      issue(2'b10, 0, t);
      exp_done.push_back(mk(t + 1, 1, 0));
      wait_until(t + 2);
      issue(2'b01, POLYDEG + 1, t);
      exp_done.push_back(mk(t + 1, 1, 0));
      wait_until(t + 2);

      // Abort during the 50th read; writes 0..33 already due by then
      issue(2'b01, 100, t);
      for (int i = 0; i < 50; i++) exp_rd.push_back(mk(t + 1 + i, i, 1));
      for (int i = 0; i < 34; i++) exp_wr.push_back(mk(t + 17 + i, i, 1));
      exp_done.push_back(mk(t + 51, 1, 0));
      wait_until(t + 50);
      cmd_abort = 1'b1;
      wait_until(t + 51);
      cmd_abort = 1'b0;
      wait_until(t + 52);
      issue(2'b00, 3, t);
      push_normal(t, 3, 0);
      wait_until(t + 3 + NPLINE + 2);

      // Full-length polynomial: addresses stop at POLYDEG-1
      issue(2'b11, POLYDEG, t);
      push_normal(t, POLYDEG, 3);
      wait_until(t + POLYDEG + NPLINE + 2);
      chk("max_rd_addr_final", int'(rd_addr), POLYDEG - 1);
      chk("max_wr_addr_final", int'(wr_addr), POLYDEG - 1);

      // Reset in DRAIN with writes 10..19 still in flight
      issue(2'b10, 20, t);
      for (int i = 0; i < 20; i++) exp_rd.push_back(mk(t + 1 + i, i, 2));
      for (int i = 0; i < 10; i++) exp_wr.push_back(mk(t + 17 + i, i, 2));
      wait_until(t + 26);
      rst = 1'b1;
      wait_until(t + 27);
      rst = 1'b0;
      chk_reset_outputs("midrst");
      issue(2'b01, 2, t2);
      chk("accept_after_reset", t2, t + 27);
      push_normal(t2, 2, 1);
      wait_until(t2 + 2 + NPLINE + 4);

      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      chk("done_left", exp_done.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
